// File: rtl/fnd_pkg.sv
// Shared definitions for the FND time display path.
// Provides the conversion FSM state type, the 7-segment codes
// ({g,f,e,d,c,b,a}, active-low) and the sizing constants used by the
// binary-to-BCD engine and the digit scanner.
package fnd_pkg;

  localparam int BIN_W   = 14;
  localparam int DIGITS  = 4;
  localparam int BCD_MAX = 9999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_LATCH = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/fnd_time_display_if.sv
// Bundle of the time display's data/control inputs and display outputs.
//   i_timeData : packed time value from the time counter (mm*100+ss)
//   i_dpOn     : light the MM/SS decimal point
//   i_blank    : turn all digits off
//   o_fndCom   : digit commons, active-low, bit0 = rightmost
//   o_fndFont  : segments {dp,g,f,e,d,c,b,a}, active-low
//   o_bcd      : latched BCD {thousands,hundreds,tens,ones}
//   o_busy     : conversion in progress
// master = the driver of the time value (time counter / bench),
// slave  = the display block.
interface fnd_time_display_if;
  import fnd_pkg::*;

  logic [BIN_W-1:0] i_timeData;
  logic             i_dpOn;
  logic             i_blank;
  logic [3:0]       o_fndCom;
  logic [7:0]       o_fndFont;
  logic [15:0]      o_bcd;
  logic             o_busy;

  modport master (
    output i_timeData, i_dpOn, i_blank,
    input  o_fndCom, o_fndFont, o_bcd, o_busy
  );

  modport slave (
    input  i_timeData, i_dpOn, i_blank,
    output o_fndCom, o_fndFont, o_bcd, o_busy
  );
endinterface

// File: rtl/time_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble).
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_start      : accepted only while idle (o_busy low)
//   i_bin        : binary value, clamped to BCD_MAX on capture
//   o_busy       : high from the capture edge until the latch edge
//   o_done       : one-cycle pulse after the result is latched
//   o_bcd        : latched four-digit BCD result
// Timing: capture at edge k, 14 shift cycles, result latched at edge k+15.
module time_bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [15:0]      o_bcd
);

  conv_state_e      state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [15:0]      acc_q, acc_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      acc_adj;

  function automatic logic [15:0] add3_nibbles(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] >= 4'd5) ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [BIN_W-1:0] clamp_bin(input logic [BIN_W-1:0] v);
    return (v > BIN_W'(BCD_MAX)) ? BIN_W'(BCD_MAX) : v;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    acc_adj = add3_nibbles(acc_q);
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          bin_d   = clamp_bin(i_bin);
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        // Correct every nibble first, then shift the next binary MSB in.
        acc_d = {acc_adj[14:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(BIN_W - 1)) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        bcd_d   = acc_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Working registers are always re-initialised on capture.
  always_ff @(posedge i_clk) begin
    bin_q <= bin_d;
    acc_q <= acc_d;
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_bcd  = bcd_q;

endmodule

// File: rtl/fnd_time_display.sv
// Four-digit common-anode FND driver for the mm:ss time value.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : time value, dp/blank controls in; commons, segments,
//                  latched BCD and busy out (see fnd_time_display_if)
// Parameters:
//   SCAN_DIV : clock cycles each digit stays selected (2..2^20)
//   DP_DIGIT : digit index (0 = rightmost) whose dp follows i_dpOn
// A new conversion starts whenever the idle converter sees an input that
// differs from the last raw value captured; changes during a conversion
// are picked up on the return to idle. The scanner free-runs.
module fnd_time_display
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DP_DIGIT = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  fnd_time_display_if.slave  bus
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [BIN_W-1:0] last_q, last_d;
  logic             start;
  logic             busy;
  logic             done;
  logic [15:0]      bcd;

  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [3:0]       com_q, com_d;
  logic [7:0]       font_q, font_d;
  logic [3:0]       nib;
  logic             dp_n;

  // Raw value is remembered so a steady out-of-range input converts once.
  always_comb begin
    start  = !busy && (bus.i_timeData != last_q);
    last_d = start ? bus.i_timeData : last_q;
  end

  time_bin2bcd_seq u_bin2bcd (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(start),
    .i_bin  (bus.i_timeData),
    .o_busy (busy),
    .o_done (done),
    .o_bcd  (bcd)
  );

  always_comb begin
    scan_cnt_d = scan_cnt_q + CNT_W'(1);
    digit_d    = digit_q;
    if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      digit_d    = digit_q + 2'd1;
    end
    nib    = bcd[4*digit_q +: 4];
    dp_n   = !((digit_q == 2'(DP_DIGIT)) && bus.i_dpOn);
    // Commons and font come from the same digit index, so they switch
    // together on one edge.
    com_d  = ~(4'b0001 << digit_q);
    font_d = {dp_n, seg_decode(nib)};
    if (bus.i_blank) begin
      com_d  = 4'b1111;
      font_d = 8'hFF;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q     <= '0;
      scan_cnt_q <= '0;
      digit_q    <= '0;
      com_q      <= 4'b1111;
      font_q     <= 8'hFF;
    end else begin
      last_q     <= last_d;
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      com_q      <= com_d;
      font_q     <= font_d;
    end
  end

  assign bus.o_fndCom  = com_q;
  assign bus.o_fndFont = font_q;
  assign bus.o_bcd     = bcd;
  assign bus.o_busy    = busy;

  logic unused_done;
  assign unused_done = done;

endmodule

// File: tb/tb_fnd_time_display.sv
module tb_fnd_time_display;
  import fnd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fnd_time_display_if bus ();

  fnd_time_display #(.SCAN_DIV(4), .DP_DIGIT(2)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int conv_cnt = 0;
  logic [15:0] exp_q[$];
  logic prev_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.o_busy && n < 40);
    chk(nm, {31'd0, bus.o_busy}, 32'd0);
  endtask

  // Monitor: every busy falling edge outside reset is a finished conversion.
  always @(negedge clk) begin
    if (!rst && prev_busy && !bus.o_busy) begin
      conv_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_conv", {16'd0, bus.o_bcd}, 32'hFFFF_FFFF);
      end else begin
        chk("conv_bcd", {16'd0, bus.o_bcd}, {16'd0, exp_q.pop_front()});
      end
    end
    prev_busy = rst ? 1'b0 : bus.o_busy;
  end

  initial begin
    logic [3:0] exp_com [4];
    logic [7:0] exp_font[4];
    logic [3:0] prev_com;
    bit found;
    int n0;
    int dp_lit;

    exp_com  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_font = '{8'h99, 8'hB0, 8'hA4, 8'hF9};   // 4,3,2,1 with dp off

    bus.i_timeData = '0;
    bus.i_dpOn     = 1'b0;
    bus.i_blank    = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_bcd",  {16'd0, bus.o_bcd}, 32'h0);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'h0);
    chk("rst_com",  {28'd0, bus.o_fndCom}, 32'hF);
    chk("rst_font", {24'd0, bus.o_fndFont}, 32'hFF);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_no_conv", {31'd0, bus.o_busy}, 32'h0);
    end

    // 0 -> 1234 : busy after edges k..k+14, result after k+15
    exp_q.push_back(16'h1234);
    bus.i_timeData = 14'd1234;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("busy_1234", {31'd0, bus.o_busy}, 32'h1);
    end
    tick();
    chk("busy_end_1234", {31'd0, bus.o_busy}, 32'h0);
    chk("bcd_1234", {16'd0, bus.o_bcd}, 32'h1234);

    // Align to the start of digit 0 and check the full scan sequence.
    found = 0;
    prev_com = bus.o_fndCom;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.o_fndCom == 4'b1110 && prev_com != 4'b1110) found = 1;
      prev_com = bus.o_fndCom;
    end
    chk("scan_align", {31'd0, found}, 32'h1);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("scan_com_d%0d_c%0d", d, c), {28'd0, bus.o_fndCom}, {28'd0, exp_com[d]});
        chk($sformatf("scan_font_d%0d_c%0d", d, c), {24'd0, bus.o_fndFont}, {24'd0, exp_font[d]});
        tick();
      end
    end

    // 5959 with decimal point on digit 2
    exp_q.push_back(16'h5959);
    bus.i_timeData = 14'd5959;
    bus.i_dpOn = 1'b1;
    tick();
    wait_idle("idle_5959");
    dp_lit = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("dp_bit", {31'd0, bus.o_fndFont[7]}, {31'd0, (bus.o_fndCom != 4'b1011)});
      if (!bus.o_fndFont[7]) dp_lit++;
    end
    chk("dp_lit_cycles", dp_lit, 32'd4);
    bus.i_dpOn = 1'b0;

    // Out-of-range input clamps and converts exactly once.
    n0 = conv_cnt;
    exp_q.push_back(16'h9999);
    bus.i_timeData = 14'd12000;
    tick();
    wait_idle("idle_12000");
    repeat (40) tick();
    chk("clamp_once", conv_cnt - n0, 32'd1);

    // 12000 (shown 9999) -> 0
    exp_q.push_back(16'h0000);
    bus.i_timeData = 14'd0;
    for (int i = 0; i < 15; i++) tick();
    chk("busy_to0", {31'd0, bus.o_busy}, 32'h1);
    chk("bcd_hold9999", {16'd0, bus.o_bcd}, 32'h9999);
    tick();
    chk("bcd_to0", {16'd0, bus.o_bcd}, 32'h0);
    tick();

    // 0100 then 0101 changed at conversion cycle 5
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0101);
    bus.i_timeData = 14'd100;
    tick();
    repeat (5) tick();
    bus.i_timeData = 14'd101;
    wait_idle("idle_0100");
    chk("bcd_0100", {16'd0, bus.o_bcd}, 32'h0100);
    for (int i = 0; i < 15; i++) tick();
    chk("bcd_still_0100", {16'd0, bus.o_bcd}, 32'h0100);
    tick();
    chk("bcd_0101", {16'd0, bus.o_bcd}, 32'h0101);

    // Reset during conversion of 0777
    bus.i_timeData = 14'd777;
    tick();
    repeat (7) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_bcd",  {16'd0, bus.o_bcd}, 32'h0);
    chk("mid_rst_busy", {31'd0, bus.o_busy}, 32'h0);
    chk("mid_rst_com",  {28'd0, bus.o_fndCom}, 32'hF);
    exp_q.push_back(16'h0777);
    rst = 1'b0;
    tick();
    chk("reconv_busy", {31'd0, bus.o_busy}, 32'h1);
    wait_idle("idle_0777");
    chk("bcd_0777", {16'd0, bus.o_bcd}, 32'h0777);

    // Blanking
    bus.i_blank = 1'b1;
    tick();
    chk("blank_com",  {28'd0, bus.o_fndCom}, 32'hF);
    chk("blank_font", {24'd0, bus.o_fndFont}, 32'hFF);
    tick();
    chk("blank_com2", {28'd0, bus.o_fndCom}, 32'hF);
    bus.i_blank = 1'b0;
    tick();
    chk("unblank_lit", {31'd0, (bus.o_fndCom != 4'b1111)}, 32'h1);

    repeat (4) tick();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fnd_time_display.md
Name: fnd_time_display

Overview:
- Display stage directly downstream of the time counter.
- Consumes the 14-bit packed time value (minutes*100 + seconds, decimal 0..9999).
- Converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto a 4-digit common-anode 7-segment display (FND) with active-low commons and segments.

Parameters:
- SCAN_DIV, 100000, i_clk cycles each digit stays selected (1 ms at 100 MHz); legal range 2..2^20.
- DP_DIGIT, 2, digit index (0 = rightmost) whose decimal point i_dpOn drives; separates MM from SS.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_timeData  in  14  binary time value from the time counter
- i_dpOn  in  1  light decimal point on digit DP_DIGIT (blink supplied by upstream)
- i_blank  in  1  1 = all digits off
- o_fndCom  out  4  digit commons, active-low; bit0 = rightmost digit
- o_fndFont  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- o_bcd  out  16  latched BCD {thousands,hundreds,tens,ones}
- o_busy  out  1  conversion in progress

Behaviour:
Reset (synchronous, i_rst high at a rising edge):
- o_bcd=16'h0000, o_busy=0, last-captured value=0, FSM=IDLE.
- Scan counter=0, digit index=0.
- o_fndCom=4'b1111, o_fndFont=8'hFF.
- Reset mid-conversion aborts it; o_bcd returns to 0.

FSM IDLE -> CONV -> LATCH -> IDLE:
- IDLE:
  - Each cycle, compare i_timeData with the last captured value.
  - If different, capture the clamped value (i_timeData > 9999 becomes 9999), store the raw value as last-captured, clear the 16-bit BCD accumulator, set o_busy=1, go to CONV.
- CONV: exactly 14 cycles. Each cycle:
  - add 3 to every BCD nibble >= 5;
  - shift {bcd, bin} left by 1.
- LATCH: one cycle. o_bcd <= accumulator, o_busy <= 0, go to IDLE.
- Latency: capture at edge k; o_bcd holds the new value after edge k+15; o_busy is high after edges k..k+14.
- Input changes while o_busy=1 are ignored. On the return to IDLE the compare against last-captured triggers a fresh conversion, so the final value always converges.
- Last-captured stores the raw (unclamped) value, so a steady out-of-range input converts once only.

Scanner (runs independently of the FSM):
- Counter counts 0..SCAN_DIV-1; at wrap, the digit index increments 0->1->2->3->0.
- Digit index d selects common bit d low (d=0: 4'b1110, d=3: 4'b0111) and nibble o_bcd[4d+3:4d].
- Commons and font are registered together; they change on the same edge, with no ghosting cycle.
- Leading zeros are displayed (e.g. "0005").
- dp bit is 0 (lit) only when d == DP_DIGIT and i_dpOn=1.
- i_blank=1: o_fndCom=4'b1111 and o_fndFont=8'hFF on the next edge. The scanner keeps counting, so un-blanking resumes mid-sequence.

Segment codes, {g..a} active-low:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- nibble > 9 = 1111111 (blank; unreachable by construction).

Decomposition:
- Shared package fnd_pkg:
  - FSM state enum (IDLE, CONV, LATCH);
  - SEG_0..SEG_9 and SEG_BLANK constants;
  - BIN_W=14, DIGITS=4, BCD_MAX=9999.
- One sub-module, time_bin2bcd_seq: the capture/CONV/LATCH engine with a start/busy/done interface, reusable by other display paths.
- Scanner and segment decode stay in the top.

Test Plan (bench uses SCAN_DIV=4):
- Reset held for 2 cycles with i_timeData=0 -> o_bcd=0000, o_busy=0, o_fndCom=1111, o_fndFont=FF; after release, no conversion starts (input equals last-captured).
- i_timeData 0 -> 1234 at edge k -> o_busy high for edges k..k+14, o_bcd=16'h1234 after edge k+15; scan shows com 1110/1101/1011/0111 with fonts 0011001/0110000/0100100/1111001, each held 4 cycles.
- i_timeData=5959 with i_dpOn=1 -> o_bcd=16'h5959; dp bit is 0 only while o_fndCom=1011.
- i_timeData=12000 -> o_bcd=16'h9999 and exactly one conversion occurs; 9999 -> 0 -> o_bcd=16'h0000 after 16 cycles.
- 0100 applied, then changed to 0101 at conversion cycle 5 -> o_bcd shows 16'h0100 first, then 16'h0101 a further 16 cycles after returning to IDLE.
- Reset asserted at conversion cycle 7 of 0777 -> o_bcd=0, o_busy=0, all commons off; after release, 0777 reconverts to 16'h0777. i_blank=1 -> o_fndCom=1111 on the next edge.
